// File: rtl/quad_cond_pkg.sv
// Shared types and Gray-code step classification for the quadrature input conditioner.
package quad_cond_pkg;

  typedef logic [1:0] quad_state_t;  // {a, b}

  localparam quad_state_t QS_00 = 2'b00;
  localparam quad_state_t QS_10 = 2'b10;
  localparam quad_state_t QS_11 = 2'b11;
  localparam quad_state_t QS_01 = 2'b01;

  typedef struct packed {
    logic legal;
    logic illegal;
    logic dir;
  } gray_ev_t;

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  function automatic gray_ev_t gray_step(input quad_state_t prev, input quad_state_t cur);
    gray_ev_t    ev;
    quad_state_t fwd;
    quad_state_t diff;
    case (prev)
      QS_00:   fwd = QS_10;
      QS_10:   fwd = QS_11;
      QS_11:   fwd = QS_01;
      default: fwd = QS_00;
    endcase
    diff       = prev ^ cur;
    ev.legal   = (diff == 2'b10) || (diff == 2'b01);
    ev.illegal = (diff == 2'b11);
    ev.dir     = (cur == fwd);
    return ev;
  endfunction

endpackage

// File: rtl/quad_diff_line.sv
// One differential line: 2-FF sync, pair validity, fault detection and glitch filter.
module quad_diff_line #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned FAULT_LEN  = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic pos_i,
  input  logic neg_i,
  input  logic hold_i,
  output logic level_o,
  output logic stable_o,
  output logic fault_o
);

  localparam int unsigned STB_W = $clog2(FILTER_LEN);
  localparam int unsigned VLD_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned FLT_W = $clog2(FAULT_LEN + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(FILTER_LEN - 1);
  localparam logic [VLD_W-1:0] VLD_MAX = VLD_W'(FILTER_LEN);
  localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FAULT_LEN);

  logic [1:0]       pos_sync_q, neg_sync_q;
  logic             cand_q, cand_d;
  logic             level_q, level_d;
  logic             stable_q, stable_d;
  logic             fault_q, fault_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [VLD_W-1:0] vld_cnt_q, vld_cnt_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             valid_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_sync_q <= '0;
      neg_sync_q <= '0;
      cand_q     <= 1'b0;
      level_q    <= 1'b0;
      stable_q   <= 1'b0;
      fault_q    <= 1'b0;
      stb_cnt_q  <= '0;
      vld_cnt_q  <= '0;
      flt_cnt_q  <= '0;
    end else begin
      pos_sync_q <= {pos_sync_q[0], pos_i};
      neg_sync_q <= {neg_sync_q[0], neg_i};
      cand_q     <= cand_d;
      level_q    <= level_d;
      stable_q   <= stable_d;
      fault_q    <= fault_d;
      stb_cnt_q  <= stb_cnt_d;
      vld_cnt_q  <= vld_cnt_d;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  always_comb begin
    valid_c   = pos_sync_q[1] ^ neg_sync_q[1];
    cand_d    = valid_c ? pos_sync_q[1] : cand_q;
    stb_cnt_d = stb_cnt_q;
    vld_cnt_d = '0;
    flt_cnt_d = '0;
    fault_d   = fault_q;
    level_d   = level_q;

    // Stable window restarts on any candidate change and saturates at FILTER_LEN-1.
    if (cand_d != cand_q)        stb_cnt_d = '0;
    else if (stb_cnt_q != STB_MAX) stb_cnt_d = stb_cnt_q + STB_W'(1);
    stable_d = (stb_cnt_d == STB_MAX);
    if (!hold_i && stable_d) level_d = cand_q;

    if (valid_c) begin
      vld_cnt_d = (vld_cnt_q == VLD_MAX) ? vld_cnt_q : vld_cnt_q + VLD_W'(1);
      if (vld_cnt_d == VLD_MAX) fault_d = 1'b0;
    end else begin
      flt_cnt_d = (flt_cnt_q == FLT_MAX) ? flt_cnt_q : flt_cnt_q + FLT_W'(1);
      if (flt_cnt_d == FLT_MAX) fault_d = 1'b1;
    end
  end

  assign level_o  = level_q;
  assign stable_o = stable_q;
  assign fault_o  = fault_q;

endmodule

// File: rtl/quad_diff_input_conditioner.sv
// Differential quadrature front-end: per-channel priming, Gray decode, step/dir and error counts.
module quad_diff_input_conditioner
  import quad_cond_pkg::*;
#(
  parameter int unsigned NUM_ENC    = 2,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned FAULT_LEN  = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_ENC-1:0]       apos,
  input  logic [NUM_ENC-1:0]       aneg,
  input  logic [NUM_ENC-1:0]       bpos,
  input  logic [NUM_ENC-1:0]       bneg,
  input  logic [NUM_ENC-1:0]       clear_err,
  output logic [NUM_ENC-1:0]       a_out,
  output logic [NUM_ENC-1:0]       b_out,
  output logic [NUM_ENC-1:0]       step,
  output logic [NUM_ENC-1:0]       dir,
  output logic [NUM_ENC-1:0]       line_fault,
  output logic [NUM_ENC*CNT_W-1:0] illegal_cnt
);

  for (genvar i = 0; i < NUM_ENC; i++) begin : g_ch
    logic        fault_a, fault_b, stable_a, stable_b, hold_c;
    logic        primed_q, primed_d;
    logic        step_q, step_d;
    logic        dir_q, dir_d;
    logic        lf_q, lf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    quad_state_t last_q, cur_c;
    gray_ev_t    ev_c;
    logic        evt_en_c;

    // Levels freeze as soon as either line of the pair is faulted.
    assign hold_c = fault_a | fault_b;

    quad_diff_line #(.FILTER_LEN(FILTER_LEN), .FAULT_LEN(FAULT_LEN)) u_line_a (
      .clock(clock), .reset(reset), .pos_i(apos[i]), .neg_i(aneg[i]), .hold_i(hold_c),
      .level_o(a_out[i]), .stable_o(stable_a), .fault_o(fault_a)
    );

    quad_diff_line #(.FILTER_LEN(FILTER_LEN), .FAULT_LEN(FAULT_LEN)) u_line_b (
      .clock(clock), .reset(reset), .pos_i(bpos[i]), .neg_i(bneg[i]), .hold_i(hold_c),
      .level_o(b_out[i]), .stable_o(stable_b), .fault_o(fault_b)
    );

    always_ff @(posedge clock) begin
      if (reset) begin
        primed_q <= 1'b0;
        step_q   <= 1'b0;
        dir_q    <= 1'b0;
        lf_q     <= 1'b0;
        cnt_q    <= '0;
        last_q   <= QS_00;
      end else begin
        primed_q <= primed_d;
        step_q   <= step_d;
        dir_q    <= dir_d;
        lf_q     <= lf_d;
        cnt_q    <= cnt_d;
        last_q   <= cur_c;
      end
    end

    // Priming lags the first load by a cycle so last_q already holds the loaded levels.
    always_comb begin
      cur_c    = {a_out[i], b_out[i]};
      ev_c     = gray_step(last_q, cur_c);
      evt_en_c = primed_q & ~lf_q;
      lf_d     = hold_c;
      primed_d = lf_q ? 1'b0 : (primed_q | (stable_a & stable_b));
      step_d   = evt_en_c & ev_c.legal;
      dir_d    = step_d ? ev_c.dir : dir_q;
      cnt_d    = cnt_q;
      if (clear_err[i])                               cnt_d = '0;
      else if (evt_en_c && ev_c.illegal && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    assign step[i]                     = step_q;
    assign dir[i]                      = dir_q;
    assign line_fault[i]               = lf_q;
    assign illegal_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_quad_diff_input_conditioner.sv
// Self-checking bench: directed scenarios plus random Gray walks against a sequence-index model.
module tb_quad_diff_input_conditioner;

  localparam int NE   = 2;
  localparam int FLT  = 8;
  localparam int FLEN = 64;
  localparam int CW   = 16;
  localparam int WIN  = FLT + 7;

  logic                clock = 1'b0;
  logic                reset;
  logic [NE-1:0]       apos, aneg, bpos, bneg, clear_err;
  logic [NE-1:0]       a_out, b_out, step, dir, line_fault;
  logic [NE*CW-1:0]    illegal_cnt;

  int   checks = 0;
  int   errors = 0;
  logic [1:0] seq_tbl [4];
  int   idx  [NE];
  int   ill  [NE];
  logic mdir [NE];

  quad_diff_input_conditioner #(
    .NUM_ENC(NE), .FILTER_LEN(FLT), .FAULT_LEN(FLEN), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .apos(apos), .aneg(aneg), .bpos(bpos), .bneg(bneg), .clear_err(clear_err),
    .a_out(a_out), .b_out(b_out), .step(step), .dir(dir),
    .line_fault(line_fault), .illegal_cnt(illegal_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_pins(input int ch, input logic a, input logic b);
    apos[ch] = a;
    aneg[ch] = ~a;
    bpos[ch] = b;
    bneg[ch] = ~b;
  endtask

  task automatic model_reset(input int start_idx);
    for (int c = 0; c < NE; c++) begin
      idx[c]  = start_idx;
      ill[c]  = 0;
      mdir[c] = 1'b0;
    end
  endtask

  // Move channel ch by delta positions along the Gray cycle: 1 forward, 3 reverse, 2 illegal.
  task automatic do_move(input int ch, input int delta, input bit with_clr, input int idle);
    logic [1:0] old_s, tgt;
    int   nidx, st_tick, st_num, oth_num, a_tick, b_tick, lvl_tick;
    logic d_seen;
    old_s   = seq_tbl[idx[ch]];
    nidx    = (idx[ch] + delta) % 4;
    tgt     = seq_tbl[nidx];
    st_tick = -1; st_num = 0; oth_num = 0; a_tick = -1; b_tick = -1; d_seen = 1'b0;
    set_pins(ch, tgt[1], tgt[0]);
    for (int t = 1; t <= WIN; t++) begin
      if (with_clr && t == FLT + 3) clear_err[ch] = 1'b1;
      tick();
      clear_err[ch] = 1'b0;
      if (step[ch]) begin
        st_num++;
        if (st_tick < 0) st_tick = t;
        d_seen = dir[ch];
      end
      if (step[1-ch]) oth_num++;
      if (a_tick < 0 && old_s[1] != tgt[1] && a_out[ch] == tgt[1]) a_tick = t;
      if (b_tick < 0 && old_s[0] != tgt[0] && b_out[ch] == tgt[0]) b_tick = t;
    end
    lvl_tick = (old_s[1] != tgt[1]) ? a_tick : b_tick;
    if (delta != 2) begin
      mdir[ch] = (delta == 1);
      check("step_count", st_num, 1);
      check("step_latency", st_tick, FLT + 3);
      check("step_dir", d_seen, mdir[ch]);
    end else begin
      ill[ch] = with_clr ? 0 : ill[ch] + 1;
      check("illegal_no_step", st_num, 0);
      check("illegal_dir_hold", dir[ch], mdir[ch]);
    end
    check("level_latency", lvl_tick, FLT + 2);
    check("levels", {a_out[ch], b_out[ch]}, tgt);
    check("illegal_cnt", illegal_cnt[ch*CW +: CW], ill[ch]);
    check("other_ch_quiet", oth_num, 0);
    idx[ch] = nidx;
    repeat (idle) tick();
  endtask

  initial begin
    int st, bad, rise, fall, r, ch, delta;
    seq_tbl   = '{2'b00, 2'b10, 2'b11, 2'b01};
    reset     = 1'b1;
    clear_err = '0;
    for (int c = 0; c < NE; c++) set_pins(c, 1'b0, 1'b0);
    model_reset(0);
    repeat (4) tick();
    check("rst_a_out", a_out, 0);
    check("rst_b_out", b_out, 0);
    check("rst_step", step, 0);
    check("rst_line_fault", line_fault, 0);
    check("rst_illegal_cnt", illegal_cnt, 0);
    reset = 1'b0;
    repeat (30) tick();

    // Forward then reverse walks on channel 0.
    for (int k = 0; k < 4; k++) do_move(0, 1, 1'b0, 25);
    for (int k = 0; k < 3; k++) do_move(0, 3, 1'b0, 25);

    // Short glitch on A (currently 1) must not reach a_out.
    st = 0; bad = 0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 1) begin apos[0] = 1'b0; aneg[0] = 1'b1; end
      if (t == 6) begin apos[0] = 1'b1; aneg[0] = 1'b0; end
      tick();
      if (step[0]) st++;
      if (a_out[0] !== 1'b1) bad++;
    end
    check("glitch_step", st, 0);
    check("glitch_a_dips", bad, 0);

    // Back to 00, then double flips: one counted, one cleared in the same cycle.
    do_move(0, 3, 1'b0, 25);
    do_move(0, 2, 1'b0, 25);
    do_move(0, 2, 1'b1, 25);

    // A pair stuck at 1/1: fault after sync + FAULT_LEN cycles + output register.
    apos[0] = 1'b1; aneg[0] = 1'b1;
    st = 0; rise = -1;
    for (int t = 1; t <= FLEN + 10; t++) begin
      tick();
      if (step[0]) st++;
      if (rise < 0 && line_fault[0]) rise = t;
    end
    check("fault_rise", rise, FLEN + 3);
    check("fault_a_hold", a_out[0], 0);
    bpos[0] = 1'b1; bneg[0] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (step[0]) st++;
    end
    check("fault_b_hold", b_out[0], 0);
    apos[0] = 1'b1; aneg[0] = 1'b0;
    fall = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (step[0]) st++;
      if (fall < 0 && !line_fault[0]) fall = t;
    end
    check("fault_clear", fall, FLT + 3);
    check("fault_no_steps", st, 0);
    check("reprime_levels", {a_out[0], b_out[0]}, 2'b11);
    check("reprime_illegal", illegal_cnt[CW-1:0], ill[0]);
    idx[0] = 2;

    // Random Gray walks on both channels.
    for (int k = 0; k < 24; k++) begin
      ch = int'($urandom_range(0, NE - 1));
      r  = int'($urandom_range(0, 9));
      delta = (r < 5) ? 1 : (r < 9) ? 3 : 2;
      do_move(ch, delta, (delta == 2) && ($urandom_range(0, 1) == 1), int'($urandom_range(2, 20)));
    end

    // Come out of reset with all pins at A=B=1.
    reset = 1'b1;
    for (int c = 0; c < NE; c++) set_pins(c, 1'b1, 1'b1);
    repeat (3) tick();
    reset = 1'b0;
    model_reset(2);
    st = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (step != '0) st++;
    end
    check("boot11_no_step", st, 0);
    check("boot11_a_out", a_out, 2'b11);
    check("boot11_b_out", b_out, 2'b11);
    check("boot11_illegal", illegal_cnt, 0);

    // Reset while a step is in flight.
    set_pins(0, 1'b0, 1'b1);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("midrst_a_out", a_out, 0);
    check("midrst_b_out", b_out, 0);
    check("midrst_step", step, 0);
    check("midrst_dir", dir, 0);
    check("midrst_line_fault", line_fault, 0);
    check("midrst_illegal", illegal_cnt, 0);
    reset = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
